// File: rtl/weights_pingpong_bram.sv
// weights_pingpong_bram: banked double-buffered weight store with burst read sequencer and 2-entry skid output
// Optional per-byte even parity storage enabled by defining WEIGHTS_PARITY_EN.
module weights_pingpong_bram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_BANKS = 2,
  localparam int BANK_BITS = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [BANK_BITS-1:0]  wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_err,
  input  logic                  rd_start,
  input  logic [BANK_BITS-1:0]  rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_base,
  input  logic [ADDR_WIDTH:0]   rd_len,
  output logic                  rd_busy,
  output logic                  rd_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  par_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
  typedef struct packed {
    logic                  last;
    logic                  perr;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;
  state_t                  state_q, state_d;
  logic [BANK_BITS-1:0]    bank_q, bank_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d;
  logic                    inf_q, inf_last_q;
  logic [1:0]              cnt_q, cnt_d;
  beat_t                   sk_q [2];
  beat_t                   sk_d [2];
  logic                    wr_err_q, wr_err_d, rd_done_q, rd_done_d;
  logic [DATA_WIDTH-1:0]   mem [NUM_BANKS*DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [BANK_BITS+ADDR_WIDTH-1:0] wr_idx, rd_idx;
  logic                    wr_ok, issue, pop, rd_perr;
  beat_t                   inf_beat, head;
  assign wr_idx = {wr_bank, wr_addr};
  assign rd_idx = {bank_q, addr_q};
  assign wr_err_d = wr_en && state_q != IDLE && wr_bank == bank_q;
  assign wr_ok = wr_en && !wr_err_d && 32'(wr_bank) < NUM_BANKS;
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
    if (issue) rd_data_q <= mem[rd_idx];
  end
`ifdef WEIGHTS_PARITY_EN
  localparam int PW = DATA_WIDTH / 8;
  function automatic logic [PW-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [PW-1:0] p;
    for (int i = 0; i < PW; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction
  logic [PW-1:0] par_mem [NUM_BANKS*DEPTH];
  logic [PW-1:0] par_rd_q;
  always_ff @(posedge clk) begin
    if (wr_ok) par_mem[wr_idx] <= byte_par(wr_data);
    if (issue) par_rd_q <= par_mem[rd_idx];
  end
  assign rd_perr = |(byte_par(rd_data_q) ^ par_rd_q);
`else
  assign rd_perr = 1'b0;
`endif
  // The SRAM output register acts as a third queue slot ahead of the skid entries.
  always_comb begin
    inf_beat = {inf_last_q, rd_perr, rd_data_q};
    head = cnt_q != 2'd0 ? sk_q[0] : inf_beat;
    m_valid = cnt_q != 2'd0 || inf_q;
    pop = m_valid && m_ready;
    cnt_d = cnt_q + {1'b0, inf_q} - {1'b0, pop};
    issue = state_q == STREAM && cnt_d < 2'd2;
    sk_d[0] = pop ? (cnt_q > 2'd1 ? sk_q[1] : inf_beat) : (cnt_q != 2'd0 ? sk_q[0] : inf_beat);
    sk_d[1] = pop ? inf_beat : (cnt_q > 2'd1 ? sk_q[1] : inf_beat);
  end
  always_comb begin
    state_d = state_q;
    bank_d = bank_q;
    addr_d = addr_q;
    rem_d = rem_q;
    rd_done_d = 1'b0;
    case (state_q)
      IDLE: if (rd_start) begin
        bank_d = rd_bank;
        addr_d = rd_base;
        rem_d = rd_len;
        rd_done_d = rd_len == '0;
        state_d = rd_len == '0 ? IDLE : STREAM;
      end
      STREAM: if (issue) begin
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = rem_q == 1 ? DRAIN : STREAM;
      end
      DRAIN: if (pop && head.last) begin
        rd_done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bank_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      inf_q <= 1'b0;
      inf_last_q <= 1'b0;
      cnt_q <= '0;
      sk_q <= '{default: '0};
      wr_err_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q <= bank_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      inf_q <= issue;
      inf_last_q <= issue && rem_q == 1;
      cnt_q <= cnt_d;
      sk_q <= sk_d;
      wr_err_q <= wr_err_d;
      rd_done_q <= rd_done_d;
    end
  end
  assign wr_err = wr_err_q;
  assign rd_done = rd_done_q;
  assign rd_busy = state_q != IDLE;
  assign m_data = head.data;
  assign m_last = m_valid && head.last;
  assign par_err = m_valid && head.perr;
endmodule

// File: tb/tb_weights_pingpong_bram.sv
// tb_weights_pingpong_bram: table-driven burst checks plus conflict, zero-length, reset and parity sequences
module tb_weights_pingpong_bram;
  logic clk = 0, reset = 1;
  logic wr_en = 0, rd_start = 0, m_ready = 0;
  logic [0:0] wr_bank = 0, rd_bank = 0;
  logic [9:0] wr_addr = 0, rd_base = 0;
  logic [10:0] rd_len = 0;
  logic [255:0] wr_data = 0, m_data;
  logic wr_err, rd_busy, rd_done, m_valid, m_last, par_err;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  weights_pingpong_bram dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err), .rd_start(rd_start), .rd_bank(rd_bank),
    .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy), .rd_done(rd_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .par_err(par_err)
  );
  typedef struct {
    int bank;
    int base;
    int len;
    bit tog;
    logic [7:0][31:0] exp;
    string nm;
  } vec_t;
  vec_t vecs [4];
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [7:0][31:0] e8(input logic [31:0] a, b, c, d, e, f, g, h);
    return {h, g, f, e, d, c, b, a};
  endfunction
  task automatic wr(input int bk, input int addr, input logic [255:0] d);
    @(negedge clk);
    wr_en = 1; wr_bank = 1'(bk); wr_addr = 10'(addr); wr_data = d;
  endtask
  task automatic run_burst(input int bk, input int base, input int len, input bit tog,
                           input logic [7:0][31:0] exp, input logic [7:0] perr, input string nm);
    int beats, first, last_hs, done_cyc, bad_hold;
    bit held;
    logic [258:0] saved;
    beats = 0; first = -1; last_hs = -1; done_cyc = -1; bad_hold = 0; held = 0; saved = '0;
    @(negedge clk);
    wr_en = 0; rd_start = 1; rd_bank = 1'(bk); rd_base = 10'(base); rd_len = 11'(len); m_ready = 0;
    for (int c = 1; c <= 100 && done_cyc < 0; c++) begin
      @(negedge clk);
      rd_start = 0;
      if (held && {m_valid, m_last, par_err, m_data} !== saved) bad_hold++;
      if (rd_done) done_cyc = c;
      if (m_valid && first < 0) first = c;
      m_ready = tog ? c[0] : 1'b1;
      held = m_valid && !m_ready;
      saved = {m_valid, m_last, par_err, m_data};
      if (m_valid && m_ready) begin
        if (beats < 8) begin
          chk({nm, " data"}, m_data, 256'(exp[beats]));
          chk({nm, " par_err"}, 256'(par_err), 256'(perr[beats]));
        end
        chk({nm, " last"}, 256'(m_last), 256'(beats == len - 1));
        beats++;
        last_hs = c;
      end
    end
    m_ready = 1;
    chk({nm, " first_valid_cycle"}, 256'(first), 256'(2));
    chk({nm, " beats"}, 256'(beats), 256'(len));
    chk({nm, " done_after_last"}, 256'(done_cyc), 256'(last_hs + 1));
    chk({nm, " stall_hold"}, 256'(bad_hold), 256'(0));
    chk({nm, " busy_end"}, 256'(rd_busy), 256'(0));
  endtask
  initial begin
    int hs, dones;
    bit fired;
    vecs[0] = '{0, 0, 8, 0, e8('h00, 'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77), "b0_len8"};
    vecs[1] = '{0, 0, 8, 1, e8('h00, 'h11, 'h22, 'h33, 'h44, 'h55, 'h66, 'h77), "b0_len8_stall"};
    vecs[2] = '{0, 'h3FE, 4, 0, e8('hAA, 'hBB, 'h00, 'h11, 0, 0, 0, 0), "wrap"};
    vecs[3] = '{1, 2, 3, 1, e8('h102, 'h103, 'h104, 0, 0, 0, 0, 0), "b1_stall"};
    repeat (2) @(negedge clk);
    chk("reset_outputs", 256'({wr_err, rd_busy, rd_done, m_valid, m_last, par_err}), 256'(0));
    reset = 0;
    for (int k = 0; k < 8; k++) wr(0, k, 256'(k * 'h11));
    wr(0, 'h3FE, 256'('hAA));
    wr(0, 'h3FF, 256'('hBB));
    for (int k = 0; k < 8; k++) wr(1, k, 256'('h100 + k));
    @(negedge clk);
    wr_en = 0;
    chk("idle_write_no_err", 256'(wr_err), 256'(0));
    for (int i = 0; i < 4; i++)
      run_burst(vecs[i].bank, vecs[i].base, vecs[i].len, vecs[i].tog, vecs[i].exp, 8'h00, vecs[i].nm);
    // Conflict: bank1 streaming (stalled) while writing bank1 then bank0.
    @(negedge clk);
    rd_start = 1; rd_bank = 1; rd_base = 0; rd_len = 8; m_ready = 0;
    @(negedge clk);
    rd_start = 0;
    wr_en = 1; wr_bank = 1; wr_addr = 5; wr_data = 256'('hDEAD);
    @(negedge clk);
    chk("conflict_wr_err", 256'(wr_err), 256'(1));
    wr_bank = 0; wr_data = 256'('hBEEF);
    @(negedge clk);
    wr_en = 0;
    chk("other_bank_no_err", 256'(wr_err), 256'(0));
    m_ready = 1;
    hs = 0;
    for (int c = 0; c < 50 && !rd_done; c++) begin
      if (m_valid && m_ready) hs++;
      @(negedge clk);
    end
    chk("conflict_burst_beats", 256'(hs), 256'(8));
    chk("conflict_burst_done", 256'(rd_done), 256'(1));
    run_burst(1, 4, 2, 0, e8('h104, 'h105, 0, 0, 0, 0, 0, 0), 8'h00, "b1_dropped");
    run_burst(0, 4, 2, 0, e8('h44, 'hBEEF, 0, 0, 0, 0, 0, 0), 8'h00, "b0_written");
    // Zero-length burst.
    @(negedge clk);
    rd_start = 1; rd_bank = 0; rd_base = 3; rd_len = 0;
    @(negedge clk);
    rd_start = 0;
    chk("len0_done_c1", 256'({rd_done, m_valid, rd_busy}), 256'(3'b100));
    @(negedge clk);
    chk("len0_done_once", 256'({rd_done, m_valid, rd_busy}), 256'(3'b000));
    @(negedge clk);
    chk("len0_no_valid", 256'(m_valid), 256'(0));
    // Reset during beat 3 of a 16-beat burst.
    @(negedge clk);
    rd_start = 1; rd_bank = 0; rd_base = 0; rd_len = 16; m_ready = 1;
    hs = 0; fired = 0;
    for (int c = 0; c < 50 && !fired; c++) begin
      @(negedge clk);
      rd_start = 0;
      if (hs == 3 && m_valid) begin
        chk("beat3_data", m_data, 256'('h33));
        reset = 1; fired = 1;
      end else if (m_valid && m_ready) hs++;
    end
    chk("reset_reached", 256'(fired), 256'(1));
    @(negedge clk);
    reset = 0;
    chk("reset_abort", 256'({m_valid, rd_busy, m_last}), 256'(0));
    dones = 0;
    repeat (5) begin
      @(negedge clk);
      if (rd_done || m_valid) dones++;
    end
    chk("reset_no_done", 256'(dones), 256'(0));
    run_burst(0, 6, 2, 0, e8('h66, 'h77, 0, 0, 0, 0, 0, 0), 8'h00, "after_reset");
`ifdef WEIGHTS_PARITY_EN
    @(negedge clk);
    dut.mem[2] = dut.mem[2] ^ 256'h1;
    run_burst(0, 0, 4, 0, e8('h00, 'h11, 'h23, 'h33, 0, 0, 0, 0), 8'b0000_0100, "parity");
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
